// File: rtl/am_request_arbiter.sv
//------------------------------------------------------------------------------
// am_request_arbiter : round-robin arbitration of NUM_REQ query requesters onto
//                      one associative memory, with result timeout and tagging.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef HV_DIMENSION
`define HV_DIMENSION 2048
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 8
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 16
`endif

module am_request_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int HV_DIMENSION   = `HV_DIMENSION,
  parameter int LABEL_WIDTH    = `LABEL_WIDTH,
  parameter int DISTANCE_WIDTH = `DISTANCE_WIDTH,
  parameter int TIMEOUT        = 255,
  localparam int TAG_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            Clk_CI,
  input  logic                            Reset_RBI,
  input  logic [NUM_REQ-1:0]              ValidIn_SI,
  output logic [NUM_REQ-1:0]              ReadyOut_SO,
  input  logic [NUM_REQ*HV_DIMENSION-1:0] HypervectorIn_DI,
  output logic                            AmValidOut_SO,
  input  logic                            AmReadyIn_SI,
  output logic [HV_DIMENSION-1:0]         AmHypervectorOut_DO,
  input  logic                            AmValidIn_SI,
  output logic                            AmReadyOut_SO,
  input  logic [LABEL_WIDTH-1:0]          AmLabel_DI,
  input  logic [DISTANCE_WIDTH-1:0]       AmDistance_DI,
  output logic                            ValidOut_SO,
  input  logic                            ReadyIn_SI,
  output logic [LABEL_WIDTH-1:0]          LabelOut_DO,
  output logic [DISTANCE_WIDTH-1:0]       DistanceOut_DO,
  output logic [TAG_W-1:0]                TagOut_DO,
  output logic                            TimeoutOut_SO
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [TAG_W-1:0]          r_ptr;
  logic [TAG_W-1:0]          r_tag;
  logic                      r_stale;
  logic [CNT_W-1:0]          r_cnt;
  logic [HV_DIMENSION-1:0]   r_hv;
  logic [LABEL_WIDTH-1:0]    r_label;
  logic [DISTANCE_WIDTH-1:0] r_dist;
  logic                      r_timeout;

  logic [HV_DIMENSION-1:0]   w_hv_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0]      w_dbl;
  logic [NUM_REQ-1:0]        w_rot;
  logic [TAG_W-1:0]          w_off;
  logic [TAG_W:0]            w_sum;
  logic [TAG_W-1:0]          w_grant;
  logic [TAG_W-1:0]          w_ptr_nxt;
  logic                      w_any;
  logic                      w_accept;
  logic                      w_cnt_max;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_hv_arr[gi] = HypervectorIn_DI[gi*HV_DIMENSION +: HV_DIMENSION];
  end

  // Rotate requests so the pointer position sits at bit 0; the lowest set bit
  // of the rotated vector is the distance from Ptr to the winning requester.
  always_comb begin
    w_dbl = {ValidIn_SI, ValidIn_SI};
    w_rot = NUM_REQ'(w_dbl >> r_ptr);
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = TAG_W'(k);
      end
    end
    w_sum   = (TAG_W+1)'(r_ptr) + (TAG_W+1)'(w_off);
    w_grant = (w_sum >= (TAG_W+1)'(NUM_REQ)) ? TAG_W'(w_sum - (TAG_W+1)'(NUM_REQ))
                                             : TAG_W'(w_sum);
    w_ptr_nxt = (w_grant == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
  end

  assign w_any     = |ValidIn_SI;
  // Reset_RBI gates the accept so ReadyOut_SO is zero for the whole reset.
  assign w_accept  = Reset_RBI && (r_state == S_IDLE) && !r_stale && w_any;
  assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    ReadyOut_SO   = w_accept ? (NUM_REQ'(1) << w_grant) : '0;
    AmValidOut_SO = 1'b0;
    AmReadyOut_SO = r_stale;
    ValidOut_SO   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        AmValidOut_SO = 1'b1;
        if (AmReadyIn_SI) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        AmReadyOut_SO = 1'b1;
        if (AmValidIn_SI || w_cnt_max) begin
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: begin
        ValidOut_SO = 1'b1;
        if (ReadyIn_SI) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      r_ptr     <= '0;
      r_tag     <= '0;
      r_stale   <= 1'b0;
      r_cnt     <= '0;
      r_hv      <= '0;
      r_label   <= '0;
      r_dist    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hv  <= w_hv_arr[w_grant];
        r_tag <= w_grant;
        r_ptr <= w_ptr_nxt;
      end

      if ((r_state == S_ISSUE) && AmReadyIn_SI) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !AmValidIn_SI && !w_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A late answer to a timed-out query arrives outside WAIT and is dropped.
      if (r_state == S_WAIT) begin
        if (AmValidIn_SI) begin
          r_label   <= AmLabel_DI;
          r_dist    <= AmDistance_DI;
          r_timeout <= 1'b0;
        end else if (w_cnt_max) begin
          r_label   <= '0;
          r_dist    <= '1;
          r_timeout <= 1'b1;
          r_stale   <= 1'b1;
        end
      end else if (r_stale && AmValidIn_SI) begin
        r_stale <= 1'b0;
      end
    end
  end

  assign AmHypervectorOut_DO = r_hv;
  assign LabelOut_DO         = r_label;
  assign DistanceOut_DO      = r_dist;
  assign TagOut_DO           = r_tag;
  assign TimeoutOut_SO       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_am_request_arbiter.sv
//------------------------------------------------------------------------------
// tb_am_request_arbiter : directed scenarios plus random traffic, all cycles
//                         checked against a transaction-level reference model.
//------------------------------------------------------------------------------
`default_nettype none

module tb_am_request_arbiter;

  localparam int N   = 3;
  localparam int HVW = 16;
  localparam int LW  = 4;
  localparam int DW  = 8;
  localparam int TO  = 4;
  localparam int TW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    vin;
  logic [N-1:0]    rdy_out;
  logic [N*HVW-1:0] hv_in;
  logic            am_vout;
  logic            am_rdy_in;
  logic [HVW-1:0]  am_hv;
  logic            am_vin;
  logic            am_rdy_out;
  logic [LW-1:0]   am_lab;
  logic [DW-1:0]   am_dist;
  logic            vout;
  logic            rdy_in;
  logic [LW-1:0]   lab_out;
  logic [DW-1:0]   dist_out;
  logic [TW-1:0]   tag_out;
  logic            to_out;

  always #5 clk = ~clk;

  am_request_arbiter #(
    .NUM_REQ(N), .HV_DIMENSION(HVW), .LABEL_WIDTH(LW),
    .DISTANCE_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .Clk_CI(clk), .Reset_RBI(rst_n),
    .ValidIn_SI(vin), .ReadyOut_SO(rdy_out), .HypervectorIn_DI(hv_in),
    .AmValidOut_SO(am_vout), .AmReadyIn_SI(am_rdy_in), .AmHypervectorOut_DO(am_hv),
    .AmValidIn_SI(am_vin), .AmReadyOut_SO(am_rdy_out),
    .AmLabel_DI(am_lab), .AmDistance_DI(am_dist),
    .ValidOut_SO(vout), .ReadyIn_SI(rdy_in),
    .LabelOut_DO(lab_out), .DistanceOut_DO(dist_out),
    .TagOut_DO(tag_out), .TimeoutOut_SO(to_out)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: stage 0 idle, 1 query pending to AM, 2 awaiting result,
  // 3 result held for the consumer.
  int            m_st, m_ptr, m_wcnt, m_tag;
  bit            m_stale, m_to;
  logic [HVW-1:0] m_hv;
  logic [LW-1:0]  m_lab;
  logic [DW-1:0]  m_dist;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_grant(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_wcnt = 0; m_tag = 0;
    m_stale = 0; m_to = 0; m_hv = '0; m_lab = '0; m_dist = '0;
  endtask

  // Check every output against the model for the current inputs, advance the
  // model across the coming rising edge, then step to just after that edge.
  task automatic cycle();
    int g, ost;
    bit ostale;
    logic [N-1:0] e_rdy;
    #1;
    g = rr_grant(m_ptr, vin);
    if (!rst_n) begin
      chk("rst_ReadyOut", rdy_out, 0);
      chk("rst_AmValid", am_vout, 0);
      chk("rst_AmHv", am_hv, 0);
      chk("rst_AmReady", am_rdy_out, 0);
      chk("rst_ValidOut", vout, 0);
      chk("rst_Label", lab_out, 0);
      chk("rst_Dist", dist_out, 0);
      chk("rst_Tag", tag_out, 0);
      chk("rst_Timeout", to_out, 0);
      model_reset();
    end else begin
      e_rdy = (m_st == 0 && !m_stale && g >= 0) ? N'(1 << g) : '0;
      chk("ReadyOut", rdy_out, e_rdy);
      chk("AmValid", am_vout, m_st == 1);
      chk("AmReady", am_rdy_out, (m_st == 2) || m_stale);
      chk("ValidOut", vout, m_st == 3);
      chk("AmHv", am_hv, m_hv);
      chk("Label", lab_out, m_lab);
      chk("Dist", dist_out, m_dist);
      chk("Tag", tag_out, m_tag);
      chk("Timeout", to_out, m_to);
      ost = m_st; ostale = m_stale;
      case (ost)
        0: if (e_rdy != 0) begin
             m_hv = hv_in[g*HVW +: HVW]; m_tag = g; m_ptr = (g + 1) % N; m_st = 1;
           end
        1: if (am_rdy_in) begin m_st = 2; m_wcnt = 0; end
        2: if (am_vin) begin
             m_lab = am_lab; m_dist = am_dist; m_to = 0; m_st = 3;
           end else if (m_wcnt == TO) begin
             m_lab = 0; m_dist = '1; m_to = 1; m_stale = 1; m_st = 3;
           end else m_wcnt++;
        default: if (rdy_in) m_st = 0;
      endcase
      if (ost != 2 && ostale && am_vin) m_stale = 0;
    end
    @(posedge clk);
    #1;
  endtask

  int             tags [$];
  logic [HVW-1:0] exp_hv;
  int             exp_tags [4] = '{0, 1, 2, 0};

  initial begin
    rst_n = 1'b0; vin = '1; hv_in = '0; am_rdy_in = 1'b0; am_vin = 1'b0;
    am_lab = '0; am_dist = '0; rdy_in = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Reset: outputs zero even with all requesters valid.
    for (int i = 0; i < 3; i++) cycle();

    // Fairness: everybody valid, AM and consumer always ready.
    rst_n = 1'b1; vin = 3'b111; am_rdy_in = 1'b1; am_vin = 1'b1; rdy_in = 1'b1;
    hv_in = {16'hC0C2, 16'hB0B1, 16'hA0A0};
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("ReadyOneHot0", $onehot0(rdy_out), 1);
      if (vout && rdy_in) tags.push_back(int'(tag_out));
      cycle();
    end
    chk("FairCount", tags.size(), 4);
    for (int i = 0; i < 4 && i < tags.size(); i++) chk("FairTag", tags[i], exp_tags[i]);

    // Requester 1 alone, AM answers label 2 / distance 100 after 3 WAIT cycles.
    vin = 3'b010; am_vin = 1'b0; rdy_in = 1'b0;
    hv_in = {$urandom, $urandom};
    exp_hv = hv_in[HVW +: HVW];
    #1 chk("R1_Ready", rdy_out, 3'b010);
    cycle();
    vin = '0;
    #1 chk("R1_AmValid", am_vout, 1);
    chk("R1_AmHv", am_hv, exp_hv);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    am_vin = 1'b1; am_lab = 4'd2; am_dist = 8'd100;
    cycle();
    am_vin = 1'b0;
    #1 chk("R1_Valid", vout, 1);
    chk("R1_Tag", tag_out, 1);
    chk("R1_Label", lab_out, 2);
    chk("R1_Dist", dist_out, 100);
    chk("R1_Timeout", to_out, 0);
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0;

    // AM never answers: timeout after 5 WAIT cycles, then stale blocks grants.
    vin = 3'b001; cycle();
    vin = '0; cycle();
    for (int i = 0; i < 5; i++) begin
      #1 chk("TO_WaitAmReady", am_rdy_out, 1);
      chk("TO_WaitNoValid", vout, 0);
      cycle();
    end
    #1 chk("TO_Valid", vout, 1);
    chk("TO_Dist", dist_out, 8'hFF);
    chk("TO_Label", lab_out, 0);
    chk("TO_Flag", to_out, 1);
    chk("TO_Tag", tag_out, 0);
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0;
    vin = 3'b111;
    for (int i = 0; i < 2; i++) begin
      #1 chk("TO_Blocked", rdy_out, 0);
      chk("TO_StaleReady", am_rdy_out, 1);
      cycle();
    end
    am_vin = 1'b1; cycle(); am_vin = 1'b0;
    #1 chk("TO_Unblocked", rdy_out, 3'b010);
    chk("TO_StaleClear", am_rdy_out, 0);
    cycle();
    vin = '0; cycle();
    am_vin = 1'b1; cycle(); am_vin = 1'b0;
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0;

    // AM answers exactly when the counter reaches TIMEOUT: real result wins.
    vin = 3'b100; cycle();
    vin = '0; cycle();
    for (int i = 0; i < TO; i++) cycle();
    am_vin = 1'b1; am_lab = 4'd5; am_dist = 8'd7;
    #1 chk("Edge_StillWait", vout, 0);
    cycle();
    am_vin = 1'b0;
    #1 chk("Edge_Valid", vout, 1);
    chk("Edge_Timeout", to_out, 0);
    chk("Edge_Label", lab_out, 5);
    chk("Edge_Dist", dist_out, 7);
    chk("Edge_Tag", tag_out, 2);
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0;
    #1 chk("Edge_NotStale", am_rdy_out, 0);

    // Consumer stalls for 10 cycles in RESPOND.
    vin = 3'b111; cycle();
    cycle();
    am_vin = 1'b1; cycle(); am_vin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("Stall_Valid", vout, 1);
      chk("Stall_NoReady", rdy_out, 0);
      chk("Stall_Tag", tag_out, 0);
      chk("Stall_Label", lab_out, 5);
      cycle();
    end
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0; vin = '0;
    #1 chk("Stall_Released", vout, 0);

    // Reset pulse during WAIT drops the query and returns Ptr to 0.
    vin = 3'b010; cycle();
    vin = '0; cycle(); cycle(); cycle();
    rst_n = 1'b0;
    #1 chk("RstW_AmReady", am_rdy_out, 0);
    chk("RstW_AmHv", am_hv, 0);
    chk("RstW_Tag", tag_out, 0);
    cycle(); cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("RstW_NoReissue", am_vout, 0);
      cycle();
    end
    vin = 3'b111;
    #1 chk("RstW_Ptr0", rdy_out, 3'b001);
    cycle();
    vin = '0; cycle();
    am_vin = 1'b1; cycle(); am_vin = 1'b0;
    rdy_in = 1'b1; cycle(); rdy_in = 1'b0;

    // Random traffic against the model, with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      vin       = N'($urandom_range(0, 7));
      hv_in     = {$urandom, $urandom};
      am_rdy_in = 1'($urandom_range(0, 1));
      am_vin    = ($urandom_range(0, 3) == 0);
      am_lab    = LW'($urandom);
      am_dist   = DW'($urandom);
      rdy_in    = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/am_request_arbiter.md
AM_REQUEST_ARBITER -- requirements
Module: am_request_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of query requesters sharing one associative memory.
REQ-002 Parameter HV_DIMENSION, default `HV_DIMENSION: query hypervector width.
REQ-003 Parameters LABEL_WIDTH and DISTANCE_WIDTH, defaults `LABEL_WIDTH and `DISTANCE_WIDTH: result field widths.
REQ-004 Parameter TIMEOUT, default 255, legal range >=1: maximum WAIT cycles before an AM result is declared lost.
REQ-005 Clk_CI  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset_RBI  in  1  asynchronous, active-low reset.
REQ-007 ValidIn_SI  in  NUM_REQ  per-requester query valid.
REQ-008 ReadyOut_SO  out  NUM_REQ  per-requester query accept.
REQ-009 HypervectorIn_DI  in  NUM_REQ*HV_DIMENSION  query vectors; requester i at [i*HV_DIMENSION +: HV_DIMENSION].
REQ-010 AmValidOut_SO  out  1 / AmReadyIn_SI  in  1  query handshake towards the AM.
REQ-011 AmHypervectorOut_DO  out  HV_DIMENSION  registered query presented to the AM.
REQ-012 AmValidIn_SI  in  1 / AmReadyOut_SO  out  1  result handshake from the AM.
REQ-013 AmLabel_DI  in  LABEL_WIDTH / AmDistance_DI  in  DISTANCE_WIDTH  AM result.
REQ-014 ValidOut_SO  out  1 / ReadyIn_SI  in  1  result handshake towards the consumer.
REQ-015 LabelOut_DO  out  LABEL_WIDTH / DistanceOut_DO  out  DISTANCE_WIDTH  registered result.
REQ-016 TagOut_DO  out  max(1,ceilLog2(NUM_REQ))  index of the requester that owns the result.
REQ-017 TimeoutOut_SO  out  1  result was synthesised by the timeout, not returned by the AM.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESPOND, with at most one query outstanding.
REQ-019 The round-robin pointer Ptr SHALL select the grant g as the first asserted ValidIn_SI bit searching Ptr, Ptr+1, ... modulo NUM_REQ.
REQ-020 In IDLE with Stale=0, ReadyOut_SO SHALL be one-hot at g when any ValidIn_SI is set, and all zero otherwise.
REQ-021 In all other states, and in IDLE with Stale=1, ReadyOut_SO SHALL be all zero.
REQ-022 On an IDLE accept the block SHALL latch vector g and tag g, set Ptr to (g+1) mod NUM_REQ and enter ISSUE.
REQ-023 ISSUE SHALL drive AmValidOut_SO=1 with AmHypervectorOut_DO stable; on AmReadyIn_SI it SHALL enter WAIT and clear the wait counter to 0.
REQ-024 WAIT SHALL drive AmReadyOut_SO=1; on AmValidIn_SI it SHALL latch AmLabel_DI and AmDistance_DI, clear TimeoutOut_SO and enter RESPOND.
REQ-025 In WAIT without AmValidIn_SI the counter SHALL increment.
REQ-026 When the counter equals TIMEOUT without AmValidIn_SI, the block SHALL set LabelOut_DO=0, DistanceOut_DO=all ones, TimeoutOut_SO=1 and Stale=1, and enter RESPOND.
REQ-027 If AmValidIn_SI coincides with counter==TIMEOUT, the real result SHALL win and Stale SHALL stay 0.
REQ-028 While Stale=1 in any state other than WAIT, AmReadyOut_SO SHALL be 1; the first AM result handshake SHALL be discarded and SHALL clear Stale.
REQ-029 RESPOND SHALL hold ValidOut_SO=1 with LabelOut_DO, DistanceOut_DO, TagOut_DO and TimeoutOut_SO stable; on ReadyIn_SI it SHALL return to IDLE.
REQ-030 Latency: AmValidOut_SO SHALL rise one cycle after the requester accept, and ValidOut_SO one cycle after the AM result handshake.
REQ-031 The wait counter width SHALL be ceilLog2(TIMEOUT+1) bits, and the counter SHALL never wrap.
REQ-032 Fairness: with all requesters continuously valid, grants SHALL follow the order 0,1,...,NUM_REQ-1,0,...

Reset
REQ-033 Asserting Reset_RBI low SHALL immediately force IDLE, Ptr=0, Stale=0 and counter=0, and SHALL drop any in-flight query.
REQ-034 During reset, all outputs SHALL be 0: ReadyOut_SO, AmValidOut_SO, AmHypervectorOut_DO, AmReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO, TagOut_DO and TimeoutOut_SO.
REQ-035 After reset deassertion, the first rising edge SHALL be able to accept a query.

Verification
REQ-036 Requester 1 is valid alone, the AM answers label 2 / distance 100 after 5 cycles -> ValidOut_SO with Tag 1, Label 2, Distance 100, Timeout 0.
REQ-037 All three requesters are continuously valid, with the AM answering immediately -> Tags 0,1,2,0 in order, and ReadyOut_SO always one-hot.
REQ-038 The AM never answers and TIMEOUT=4 -> RESPOND after 5 WAIT cycles with Distance all ones and Timeout 1; the next grant is blocked until one AM result is drained.
REQ-039 The AM answers in exactly the cycle where counter==TIMEOUT -> the real result is output, Timeout 0, Stale 0.
REQ-040 ReadyIn_SI is held low for 10 cycles in RESPOND -> outputs stay stable and no ReadyOut_SO is asserted; ReadyIn_SI high -> return to IDLE.
REQ-041 Reset_RBI is pulsed low during WAIT -> all outputs are 0 immediately; after release the query is not reissued and Ptr=0.
